// File: rtl/polygon_pkg.sv
// Shared types and defaults for the polygon vertex buffer.
package polygon_pkg;

    localparam int WORLD_BITS       = 32;
    localparam int MAX_NUM_VERTICES = 32;

    typedef logic signed [WORLD_BITS-1:0]            world_t;
    typedef logic [$clog2(MAX_NUM_VERTICES+1)-1:0]   vcount_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        PENDING = 2'd2
    } poly_buf_state_t;

endpackage

// File: rtl/bbox_accumulator.sv
// Running signed min/max of the vertices stored into the shadow bank.
// Only instantiated when POLY_BBOX_EN is defined.
module bbox_accumulator #(
    parameter int WORLD_BITS = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         clear_in,
    input  logic                         enable_in,
    input  logic signed [WORLD_BITS-1:0] x_in,
    input  logic signed [WORLD_BITS-1:0] y_in,
    output logic signed [WORLD_BITS-1:0] xmin_out,
    output logic signed [WORLD_BITS-1:0] xmax_out,
    output logic signed [WORLD_BITS-1:0] ymin_out,
    output logic signed [WORLD_BITS-1:0] ymax_out
);

    logic signed [WORLD_BITS-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic signed [WORLD_BITS-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic                         empty_q, empty_d;

    // First stored vertex seeds the box; later ones widen it.
    always_comb begin
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        empty_d = empty_q;
        if (clear_in) begin
            xmin_d  = '0;
            xmax_d  = '0;
            ymin_d  = '0;
            ymax_d  = '0;
            empty_d = 1'b1;
        end else if (enable_in) begin
            empty_d = 1'b0;
            if (empty_q) begin
                xmin_d = x_in;
                xmax_d = x_in;
                ymin_d = y_in;
                ymax_d = y_in;
            end else begin
                xmin_d = (x_in < xmin_q) ? x_in : xmin_q;
                xmax_d = (x_in > xmax_q) ? x_in : xmax_q;
                ymin_d = (y_in < ymin_q) ? y_in : ymin_q;
                ymax_d = (y_in > ymax_q) ? y_in : ymax_q;
            end
        end else begin
            empty_d = empty_q;
        end
    end

    // Box state registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            empty_q <= 1'b1;
        end else begin
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            empty_q <= empty_d;
        end
    end

    assign xmin_out = xmin_q;
    assign xmax_out = xmax_q;
    assign ymin_out = ymin_q;
    assign ymax_out = ymax_q;

endmodule

// File: rtl/polygon_buffer.sv
// Double-buffered polygon vertex store: shadow bank fills from a stream, active bank
// updates only on a frame swap while complete. POLY_BBOX_EN adds a committed bounding box.
module polygon_buffer #(
    parameter int WORLD_BITS       = polygon_pkg::WORLD_BITS,
    parameter int MAX_NUM_VERTICES = polygon_pkg::MAX_NUM_VERTICES
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic signed [WORLD_BITS-1:0]         vertex_x_in,
    input  logic signed [WORLD_BITS-1:0]         vertex_y_in,
    input  logic                                 vertex_valid_in,
    input  logic                                 vertex_last_in,
    output logic                                 vertex_ready_out,
    input  logic                                 frame_swap_in,
    output logic signed [WORLD_BITS-1:0]         poly_xs_out [MAX_NUM_VERTICES],
    output logic signed [WORLD_BITS-1:0]         poly_ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0] num_points_out,
    output logic                                 pending_out,
    output logic                                 overflow_out
`ifdef POLY_BBOX_EN
    ,
    output logic signed [WORLD_BITS-1:0]         bbox_xmin_out,
    output logic signed [WORLD_BITS-1:0]         bbox_xmax_out,
    output logic signed [WORLD_BITS-1:0]         bbox_ymin_out,
    output logic signed [WORLD_BITS-1:0]         bbox_ymax_out
`endif
);

    import polygon_pkg::*;

    localparam int             CW       = $clog2(MAX_NUM_VERTICES + 1);
    localparam logic [CW-1:0]  CAP      = CW'(MAX_NUM_VERTICES);
    localparam logic [CW-1:0]  MIN_POLY = CW'(3);

    typedef logic signed [WORLD_BITS-1:0] coord_t;

    poly_buf_state_t state_q, state_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d, cnt_next_s, num_q, num_d;
    logic            sh_ovf_q, sh_ovf_d, ovf_q, ovf_d;
    logic            ready_q, pending_q;
    logic            accept_s, store_s, commit_s;
    coord_t          sh_x_q [MAX_NUM_VERTICES];
    coord_t          sh_x_d [MAX_NUM_VERTICES];
    coord_t          sh_y_q [MAX_NUM_VERTICES];
    coord_t          sh_y_d [MAX_NUM_VERTICES];
    coord_t          act_x_q [MAX_NUM_VERTICES];
    coord_t          act_x_d [MAX_NUM_VERTICES];
    coord_t          act_y_q [MAX_NUM_VERTICES];
    coord_t          act_y_d [MAX_NUM_VERTICES];

    assign accept_s   = vertex_valid_in && ready_q;
    assign store_s    = accept_s && (wr_cnt_q != CAP);
    assign commit_s   = (state_q == PENDING) && frame_swap_in;
    assign cnt_next_s = store_s ? (wr_cnt_q + CW'(1)) : wr_cnt_q;

    // Shadow fill, state transitions and commit of shadow into the active bank.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        sh_ovf_d = sh_ovf_q;
        num_d    = num_q;
        ovf_d    = ovf_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            if (store_s && (wr_cnt_q == CW'(i))) begin
                sh_x_d[i] = vertex_x_in;
                sh_y_d[i] = vertex_y_in;
            end else begin
                sh_x_d[i] = sh_x_q[i];
                sh_y_d[i] = sh_y_q[i];
            end
        end
        case (state_q)
            IDLE, LOADING: begin
                if (accept_s) begin
                    if (!store_s) begin
                        sh_ovf_d = 1'b1;
                    end else begin
                        sh_ovf_d = sh_ovf_q;
                    end
                    // Fewer than three points cannot enclose anything, so publish it as empty.
                    if (vertex_last_in) begin
                        state_d  = PENDING;
                        wr_cnt_d = (cnt_next_s < MIN_POLY) ? CW'(0) : cnt_next_s;
                    end else begin
                        state_d  = LOADING;
                        wr_cnt_d = cnt_next_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            PENDING: begin
                if (frame_swap_in) begin
                    act_x_d  = sh_x_q;
                    act_y_d  = sh_y_q;
                    num_d    = wr_cnt_q;
                    ovf_d    = sh_ovf_q;
                    wr_cnt_d = CW'(0);
                    sh_ovf_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = PENDING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Buffer state, shadow/active banks and handshake flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            wr_cnt_q  <= '0;
            sh_ovf_q  <= 1'b0;
            num_q     <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
            sh_x_q    <= '{default: '0};
            sh_y_q    <= '{default: '0};
            act_x_q   <= '{default: '0};
            act_y_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            sh_ovf_q  <= sh_ovf_d;
            num_q     <= num_d;
            ovf_q     <= ovf_d;
            ready_q   <= (state_d != PENDING);
            pending_q <= (state_d == PENDING);
            sh_x_q    <= sh_x_d;
            sh_y_q    <= sh_y_d;
            act_x_q   <= act_x_d;
            act_y_q   <= act_y_d;
        end
    end

    assign vertex_ready_out = ready_q;
    assign pending_out      = pending_q;
    assign overflow_out     = ovf_q;
    assign num_points_out   = num_q;
    assign poly_xs_out      = act_x_q;
    assign poly_ys_out      = act_y_q;

`ifdef POLY_BBOX_EN
    coord_t acc_xmin_s, acc_xmax_s, acc_ymin_s, acc_ymax_s;
    coord_t bb_xmin_q, bb_xmax_q, bb_ymin_q, bb_ymax_q;

    bbox_accumulator #(
        .WORLD_BITS (WORLD_BITS)
    ) u_bbox (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (commit_s),
        .enable_in (store_s),
        .x_in      (vertex_x_in),
        .y_in      (vertex_y_in),
        .xmin_out  (acc_xmin_s),
        .xmax_out  (acc_xmax_s),
        .ymin_out  (acc_ymin_s),
        .ymax_out  (acc_ymax_s)
    );

    // Active box is committed with the arrays; an empty polygon publishes a zero box.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bb_xmin_q <= '0;
            bb_xmax_q <= '0;
            bb_ymin_q <= '0;
            bb_ymax_q <= '0;
        end else if (commit_s && (wr_cnt_q != CW'(0))) begin
            bb_xmin_q <= acc_xmin_s;
            bb_xmax_q <= acc_xmax_s;
            bb_ymin_q <= acc_ymin_s;
            bb_ymax_q <= acc_ymax_s;
        end else if (commit_s) begin
            bb_xmin_q <= '0;
            bb_xmax_q <= '0;
            bb_ymin_q <= '0;
            bb_ymax_q <= '0;
        end else begin
            bb_xmin_q <= bb_xmin_q;
            bb_xmax_q <= bb_xmax_q;
            bb_ymin_q <= bb_ymin_q;
            bb_ymax_q <= bb_ymax_q;
        end
    end

    assign bbox_xmin_out = bb_xmin_q;
    assign bbox_xmax_out = bb_xmax_q;
    assign bbox_ymin_out = bb_ymin_q;
    assign bbox_ymax_out = bb_ymax_q;
`else
    logic unused_commit_s;
    assign unused_commit_s = commit_s;
`endif

endmodule

// File: tb/tb_polygon_buffer.sv
// Scoreboard bench for polygon_buffer (MAX_NUM_VERTICES=4): each commit seen on the
// falling edge of pending_out is compared against the expected polygon queued by stimulus.
module tb_polygon_buffer;

    localparam int WB = 32;
    localparam int NV = 4;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic signed [WB-1:0] vertex_x_in, vertex_y_in;
    logic                 vertex_valid_in, vertex_last_in, vertex_ready_out;
    logic                 frame_swap_in;
    logic signed [WB-1:0] poly_xs_out [NV];
    logic signed [WB-1:0] poly_ys_out [NV];
    logic [2:0]           num_points_out;
    logic                 pending_out, overflow_out;
`ifdef POLY_BBOX_EN
    logic signed [WB-1:0] bbox_xmin_out, bbox_xmax_out, bbox_ymin_out, bbox_ymax_out;
`endif

    typedef struct {
        int n;
        int xs [4];
        int ys [4];
        bit ovf;
        int bb [4];
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_pend = 1'b0;

    polygon_buffer #(
        .WORLD_BITS       (WB),
        .MAX_NUM_VERTICES (NV)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .vertex_x_in      (vertex_x_in),
        .vertex_y_in      (vertex_y_in),
        .vertex_valid_in  (vertex_valid_in),
        .vertex_last_in   (vertex_last_in),
        .vertex_ready_out (vertex_ready_out),
        .frame_swap_in    (frame_swap_in),
        .poly_xs_out      (poly_xs_out),
        .poly_ys_out      (poly_ys_out),
        .num_points_out   (num_points_out),
        .pending_out      (pending_out),
        .overflow_out     (overflow_out)
`ifdef POLY_BBOX_EN
        ,
        .bbox_xmin_out    (bbox_xmin_out),
        .bbox_xmax_out    (bbox_xmax_out),
        .bbox_ymin_out    (bbox_ymin_out),
        .bbox_ymax_out    (bbox_ymax_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int n, input int x0, input int x1, input int x2, input int x3,
                        input int y0, input int y1, input int y2, input int y3, input bit ovf,
                        input int bxmin, input int bxmax, input int bymin, input int bymax);
        exp_t e;
        e.n   = n;
        e.xs  = '{x0, x1, x2, x3};
        e.ys  = '{y0, y1, y2, y3};
        e.ovf = ovf;
        e.bb  = '{bxmin, bxmax, bymin, bymax};
        sb_q.push_back(e);
    endtask

    task automatic send(input int x, input int y, input bit last, input bit swap);
        check("ready_before_send", vertex_ready_out, 1);
        vertex_x_in     = x;
        vertex_y_in     = y;
        vertex_valid_in = 1'b1;
        vertex_last_in  = last;
        frame_swap_in   = swap;
        @(posedge clk_in);
        #1;
        vertex_valid_in = 1'b0;
        vertex_last_in  = 1'b0;
        frame_swap_in   = 1'b0;
    endtask

    task automatic pulse_swap();
        frame_swap_in = 1'b1;
        @(posedge clk_in);
        #1;
        frame_swap_in = 1'b0;
    endtask

    // Monitor: a commit is the pending->not-pending transition outside reset.
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && !pending_out) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_commit", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("commit_num", num_points_out, e.n);
                    check("commit_ovf", overflow_out, e.ovf);
                    for (int i = 0; i < e.n; i++) begin
                        check("commit_x", poly_xs_out[i], e.xs[i]);
                        check("commit_y", poly_ys_out[i], e.ys[i]);
                    end
`ifdef POLY_BBOX_EN
                    check("bbox_xmin", bbox_xmin_out, e.bb[0]);
                    check("bbox_xmax", bbox_xmax_out, e.bb[1]);
                    check("bbox_ymin", bbox_ymin_out, e.bb[2]);
                    check("bbox_ymax", bbox_ymax_out, e.bb[3]);
`endif
                end
            end
            prev_pend = pending_out;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog_timeout actual=expired required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in          = 1'b1;
        vertex_x_in     = '0;
        vertex_y_in     = '0;
        vertex_valid_in = 1'b0;
        vertex_last_in  = 1'b0;
        frame_swap_in   = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("reset_num", num_points_out, 0);
        check("reset_pending", pending_out, 0);
        check("reset_ovf", overflow_out, 0);
        check("reset_ready", vertex_ready_out, 1);
        check("reset_x0", poly_xs_out[0], 0);

        // Square: waits in PENDING until the swap.
        send(0, 0, 1'b0, 1'b0);
        send(10, 0, 1'b0, 1'b0);
        send(10, 10, 1'b0, 1'b0);
        send(0, 10, 1'b1, 1'b0);
        check("sq_pending", pending_out, 1);
        check("sq_ready_low", vertex_ready_out, 0);
        check("sq_num_before_swap", num_points_out, 0);
        @(posedge clk_in);
        #1;
        check("sq_still_pending", pending_out, 1);
        push(4, 0, 10, 10, 0, 0, 0, 10, 10, 1'b0, 0, 10, 0, 10);
        pulse_swap();
        check("sq_num", num_points_out, 4);
        check("sq_x1", poly_xs_out[1], 10);
        check("sq_pending_clr", pending_out, 0);
        check("sq_ready_high", vertex_ready_out, 1);

        // Swap during loading is ignored.
        send(1, 1, 1'b0, 1'b0);
        send(5, 1, 1'b0, 1'b0);
        pulse_swap();
        check("midload_num_kept", num_points_out, 4);
        check("midload_x0_kept", poly_xs_out[0], 0);
        check("midload_not_pending", pending_out, 0);
        send(5, 5, 1'b0, 1'b0);
        send(1, 5, 1'b1, 1'b0);
        push(4, 1, 5, 5, 1, 1, 1, 5, 5, 1'b0, 1, 5, 1, 5);
        pulse_swap();

        // Overflow: six vertices into four slots.
        for (int k = 1; k <= 6; k++) begin
            send(k, 2 * k, (k == 6), 1'b0);
        end
        push(4, 1, 2, 3, 4, 2, 4, 6, 8, 1'b1, 1, 4, 2, 8);
        pulse_swap();
        check("ovf_flag", overflow_out, 1);
        send(0, 0, 1'b0, 1'b0);
        send(4, 0, 1'b0, 1'b0);
        send(0, 4, 1'b1, 1'b0);
        push(3, 0, 4, 0, 0, 0, 0, 4, 0, 1'b0, 0, 4, 0, 4);
        pulse_swap();

        // Degenerate: two points publish an empty polygon.
        send(7, 7, 1'b0, 1'b0);
        send(8, 8, 1'b1, 1'b0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0);
        pulse_swap();

        // Last and swap in the same cycle: only enter PENDING.
        send(2, 2, 1'b0, 1'b0);
        send(9, 2, 1'b0, 1'b0);
        send(2, 9, 1'b1, 1'b1);
        check("simul_pending", pending_out, 1);
        check("simul_num_kept", num_points_out, 0);
        push(3, 2, 9, 2, 0, 2, 2, 9, 0, 1'b0, 2, 9, 2, 9);
        pulse_swap();

        // Async reset between edges while PENDING.
        send(3, 3, 1'b0, 1'b0);
        send(6, 3, 1'b0, 1'b0);
        send(6, 6, 1'b1, 1'b0);
        check("rst_pre_pending", pending_out, 1);
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst_pending", pending_out, 0);
        check("async_rst_num", num_points_out, 0);
        check("async_rst_x1", poly_xs_out[1], 0);
        check("async_rst_y1", poly_ys_out[1], 0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("post_rst_ready", vertex_ready_out, 1);
        send(-3, -3, 1'b0, 1'b0);
        send(6, -3, 1'b0, 1'b0);
        send(-3, 6, 1'b1, 1'b0);
        push(3, -3, 6, -3, 0, -3, -3, 6, 0, 1'b0, -3, 6, -3, 6);
        pulse_swap();

        repeat (3) @(posedge clk_in);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
